// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO plus a drain sequencer that feeds an
// async_transmitter one byte at a time using a start pulse / busy handshake.
//
// Handshake: a byte is offered by a one-cycle tx_start with tx_data valid in
// the same cycle; the transmitter acknowledges by raising tx_busy within
// BUSY_TIMEOUT cycles and signals completion by dropping it. The next byte is
// only launched once tx_busy is low and the sequencer is back in IDLE.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          tx_en,
    input  logic          ovf_clr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    output logic [1:0]    dbg_state
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          start_q, start_d;
    logic [7:0]    data_q, data_d;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          push_ok, push_drop, pop;

    // Push qualification on pre-edge state; flush swallows a same-cycle push.
    always_comb begin
        push_ok   = wr_en && !full_q && !flush;
        push_drop = wr_en &&  full_q && !flush;
    end

    // Sequencer: next state, timer and the pop decision.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tx_en && !empty_q && !tx_busy && !flush) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TMO_LAST) begin
                    // Transmitter never acknowledged: give the byte up.
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping and registered output values.
    always_comb begin
        wp_d    = push_ok ? wp_q + PTR_ONE : wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            rp_d    = wp_q;
            count_d = '0;
        end else begin
            if (pop) begin
                rp_d = rp_q + PTR_ONE;
            end
            if (push_ok && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (!push_ok && pop) begin
                count_d = count_q - CNT_ONE;
            end
        end
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
        // A set in the same cycle as a clear wins.
        ovf_d   = push_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        start_d = pop;
        data_d  = pop ? mem[rp_q] : data_q;
    end

    // Storage array; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp_q] <= wr_data;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            start_q <= start_d;
            data_q  <= data_d;
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed vectors, a transmitter model, and a
// scoreboard that matches every start pulse against the expected byte queue.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int BT    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_LAUNCH = 2'd1, ST_WB = 2'd2, ST_WD = 2'd3;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        flush = 1'b0;
    logic        tx_en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        full, empty, overflow, tx_start;
    logic [AW:0] count;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;
    int busy_len = 110;
    int busy_cnt = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .tx_en(tx_en), .ovf_clr(ovf_clr), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Transmitter model: samples tx_start at a rising edge, then stays busy
    // for busy_len cycles (never busy when busy_len is 0).
    always @(posedge clk) begin
        if (!clr) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_start && busy_len > 0) begin
            tx_busy  <= 1'b1;
            busy_cnt <= busy_len - 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            tx_busy  <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every start pulse must carry the oldest expected byte.
    task automatic monitor_loop();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (clr && tx_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    check("unexpected_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", {24'h0, tx_data}, {24'h0, e});
                end
            end
        end
    endtask

    // Drivers: all called at a falling edge and return at a falling edge.
    task automatic push(input logic [7:0] d, input bit expect_tx);
        wr_en = 1'b1;
        wr_data = d;
        if (expect_tx) exp_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int n = 0;
        while (dbg_state !== s && n < 2000) begin @(negedge clk); n++; end
        check(name, {30'h0, dbg_state}, {30'h0, s});
    endtask

    task automatic wait_count(input int c, input string name);
        int n = 0;
        while (count !== (AW+1)'(c) && n < 2000) begin @(negedge clk); n++; end
        check(name, {27'h0, count}, c);
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (!(empty === 1'b1 && dbg_state === ST_IDLE && tx_busy === 1'b0) && n < 5000) begin
            @(negedge clk); n++;
        end
        check(name, n < 5000, 1);
    endtask

    initial begin
        int s0;
        fork monitor_loop(); join_none

        // Reset and release
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("rst_count", {27'h0, count}, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", {24'h0, tx_data}, 0);
        check("rst_state", {30'h0, dbg_state}, ST_IDLE);

        // Single byte, slow transmitter
        busy_len = 110;
        tx_en = 1'b1;
        s0 = n_starts;
        push(8'h41, 1);
        check("single_cnt1", {27'h0, count}, 1);
        check("single_nostart_e0", tx_start, 0);
        @(negedge clk);
        check("single_start", tx_start, 1);
        check("single_cnt0", {27'h0, count}, 0);
        check("single_empty", empty, 1);
        @(negedge clk);
        check("single_pulse_width", tx_start, 0);
        check("single_data_hold", {24'h0, tx_data}, 32'h41);
        check("single_wait_busy", {30'h0, dbg_state}, ST_WB);
        @(negedge clk);
        check("single_wait_done", {30'h0, dbg_state}, ST_WD);
        wait_drained("single_drain");
        check("single_nstarts", n_starts - s0, 1);

        // Fill and overflow with drain disabled
        busy_len = 6;
        tx_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push(8'(i), i < 16);
            check("fill_count", {27'h0, count}, (i < 16) ? i + 1 : 16);
            if (i == 14) check("fill_not_full", full, 0);
        end
        check("fill_full", full, 1);
        check("fill_ovf", overflow, 1);
        pulse_ovf_clr();
        check("ovf_cleared", overflow, 0);
        // Set beats clear in the same cycle
        wr_en = 1'b1; wr_data = 8'hDD; ovf_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_prio", overflow, 1);
        check("ovf_count_held", {27'h0, count}, 16);
        pulse_ovf_clr();
        check("ovf_cleared2", overflow, 0);

        // Push while full on the pop edge: dropped, overflow set
        tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        check("fullpop_count", {27'h0, count}, 15);
        check("fullpop_ovf", overflow, 1);
        check("fullpop_start", tx_start, 1);
        check("fullpop_notfull", full, 0);
        pulse_ovf_clr();

        // Wrap-around: drain 10 total, then push 8 more, then drain all
        wait_count(6, "wrap_drain10");
        tx_en = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h80 + 8'(i), 1);
        check("wrap_count14", {27'h0, count}, 14);
        tx_en = 1'b1;
        wait_drained("wrap_drain");
        check("wrap_all_seen", exp_q.size(), 0);

        // Simultaneous push and pop with count 3
        tx_en = 1'b0;
        push(8'h30, 1); push(8'h31, 1); push(8'h32, 1);
        check("simul_pre", {27'h0, count}, 3);
        tx_en = 1'b1; wr_en = 1'b1; wr_data = 8'h33; exp_q.push_back(8'h33);
        @(negedge clk);
        wr_en = 1'b0;
        check("simul_count", {27'h0, count}, 3);
        check("simul_start", tx_start, 1);
        wait_drained("simul_drain");

        // Flush during WAIT_DONE with count 4
        busy_len = 20;
        tx_en = 1'b0;
        s0 = n_starts;
        push(8'h50, 1);
        for (int i = 1; i < 5; i++) push(8'h50 + 8'(i), 0);
        check("flush_pre5", {27'h0, count}, 5);
        tx_en = 1'b1;
        wait_state(ST_WD, "flush_reach_wd");
        check("flush_pre4", {27'h0, count}, 4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_count", {27'h0, count}, 0);
        check("flush_empty", empty, 1);
        check("flush_state_kept", {30'h0, dbg_state}, ST_WD);
        wait_drained("flush_drain");
        repeat (10) @(negedge clk);
        check("flush_nstarts", n_starts - s0, 1);

        // Busy timeout: transmitter never goes busy
        busy_len = 0;
        s0 = n_starts;
        push(8'h60, 1);
        push(8'h61, 1);
        wait_state(ST_WB, "tmo_reach_wb");
        begin
            int n = 0;
            while (dbg_state === ST_WB && n < 20) begin @(negedge clk); n++; end
            check("tmo_cycles", n, BT);
        end
        check("tmo_back_idle", {30'h0, dbg_state}, ST_IDLE);
        @(negedge clk);
        check("tmo_next_start", tx_start, 1);
        wait_drained("tmo_drain");
        check("tmo_nstarts", n_starts - s0, 2);

        // Reset mid-transmission with count 5
        busy_len = 110;
        tx_en = 1'b0;
        push(8'h70, 1);
        for (int i = 1; i < 6; i++) push(8'h70 + 8'(i), 0);
        tx_en = 1'b1;
        wait_state(ST_WD, "rstmid_reach_wd");
        check("rstmid_pre", {27'h0, count}, 5);
        s0 = n_starts;
        clr = 1'b0;
        #1;
        check("rstmid_count", {27'h0, count}, 0);
        check("rstmid_empty", empty, 1);
        check("rstmid_state", {30'h0, dbg_state}, ST_IDLE);
        check("rstmid_data", {24'h0, tx_data}, 0);
        check("rstmid_start", tx_start, 0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        check("rstrel_empty", empty, 1);
        repeat (20) @(negedge clk);
        check("rstrel_nostart", n_starts - s0, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and drain sequencer that sits directly upstream of the `async_transmitter` in the UART transmit path. It lets the bus side queue characters without polling `TxD_busy` for each one. Bytes written by the bus slave are stored in a circular FIFO. A small state machine pops them one at a time: for each byte it drives a one-cycle start pulse with the data, then waits for the transmitter to go busy and back idle before launching the next byte.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries; power of two, 2..256.
- `AW`, 4, log2(`DEPTH`).
- `BUSY_TIMEOUT`, 4, cycles to wait for `tx_busy` to rise after a start pulse before abandoning the wait.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `clr` in 1: reset, asynchronous assert, active-low; synchronous release to `clk` is the integrator's responsibility.
- `wr_en` in 1: push request, qualified per cycle.
- `wr_data` in 8: byte to push.
- `flush` in 1: synchronous FIFO discard.
- `tx_en` in 1: drain enable; 0 holds queued bytes.
- `ovf_clr` in 1: clears the sticky overflow flag.
- `full` out 1: count == `DEPTH`.
- `empty` out 1: count == 0.
- `count` out AW+1: stored entries, 0..`DEPTH`.
- `overflow` out 1: sticky; set on a push while full.
- `tx_start` out 1: start pulse to the transmitter.
- `tx_data` out 8: byte to the transmitter.
- `tx_busy` in 1: transmitter busy, synchronous to `clk`.

## Operation
- **Storage:** `DEPTH`×8 array, with read pointer `rp` and write pointer `wp`, each AW bits. Pointers wrap modulo `DEPTH` (natural overflow). `count` is AW+1 bits.
- **Push:** accepted when `wr_en` and `count` < `DEPTH`, evaluated on pre-edge state. On accept: mem[wp] ← `wr_data`, then `wp`+1.
- **Push while full:** dropped even if a pop occurs in the same cycle; sets `overflow`.
- **Pop:** occurs only on the IDLE→LAUNCH transition. On pop: `tx_data` ← mem[rp], then `rp`+1.
- **Push and pop in the same cycle:** `count` unchanged; both pointers advance.
- **`flush`:** `rp` ← `wp`, `count` ← 0. Any push in the same cycle is discarded and does not set `overflow`. A byte already handed to the transmitter still completes, and the FSM keeps its state.
- **`overflow`:** set has priority over `ovf_clr` in the same cycle.
- **FSM states:**
  - IDLE: if `tx_en` & ~`empty` & ~`tx_busy` & ~`flush`, then pop, `tx_start` ← 1, go to LAUNCH.
  - LAUNCH: `tx_start` ← 0, clear timer, go to WAIT_BUSY.
  - WAIT_BUSY: if `tx_busy`, go to WAIT_DONE. Otherwise increment the timer; when the timer reaches `BUSY_TIMEOUT`-1, go to IDLE, and the byte is lost.
  - WAIT_DONE: if ~`tx_busy`, go to IDLE.
- **Drain enable:** `tx_en` only gates the IDLE→LAUNCH transition. Deasserting it mid-byte does not abort the byte.
- **Output registers:** `tx_start`, `tx_data`, `full`, `empty`, `count` and `overflow` are all registered.

## Timing
- **Reset values:** `tx_start`=0, `tx_data`=0x00, `count`=0, `empty`=1, `full`=0, `overflow`=0, state IDLE, `rp`=`wp`=0, timer 0.
- **Reset mid-operation:** returns to reset values immediately (asynchronous). FIFO contents are undefined but unreachable.
- **Flag timing:** `count`, `empty` and `full` update on the same edge that accepts the push or pop.
- **Write-to-start latency:** with the FSM in IDLE, `tx_en`=1 and `tx_busy`=0, a push accepted at edge E0 gives `empty`=0 after E0. `tx_start` and `tx_data` are then valid after E1, for exactly one cycle.
- **Start pulse:** one cycle wide, with `tx_data` stable from that cycle until the next pop.
- **Transmitter handshake:** the transmitter samples the start pulse at edge E2 and raises `tx_busy` after E2. The FSM reaches WAIT_BUSY after E2 and WAIT_DONE after E3.
- **Inter-byte gap:** if `tx_busy` falls after edge Ek, the FSM is in IDLE after Ek+1 and the next `tx_start` is high after Ek+2.

## Test plan
- **Reset:** assert `clr`=0 mid-transmission with `count`=5 → all outputs at reset values within the same cycle, and `empty`=1 after release.
- **Single byte:** push 0x41 with an idle transmitter model (busy for 110 cycles) → `tx_start` high one cycle after the accept edge, `tx_data`=0x41, `count` 1→0, one start pulse total.
- **Fill and overflow:** with `tx_en`=0, push 17 bytes 0x00..0x10 → `full`=1 and `count`=16 after the 16th; the 17th sets `overflow`=1 and `count` stays 16. `ovf_clr` → `overflow`=0.
- **Ordering and wrap-around:** push 16 bytes, drain 10, push 8 more, drain all → transmitter receives the 24 bytes in write order, with no duplicates.
- **Simultaneous push and pop:** push on the exact cycle of IDLE→LAUNCH with `count`=3 → `count` stays 3. Push while full on the pop edge → the push is dropped and `overflow`=1.
- **Flush and timeout:**
  - `flush` during WAIT_DONE with `count`=4 → `count`=0 at once; the current byte finishes and no further `tx_start` occurs.
  - Model that never asserts `tx_busy` → FSM returns to IDLE after `BUSY_TIMEOUT` cycles in WAIT_BUSY, and the next byte launches.
